// File: rtl/max_uint64_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial unsigned max unit.
package max_uint_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF  = 64;
    localparam int DIGIT_DEF  = 4;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n_digits);
        return (n_digits > 1) ? $clog2(n_digits) : 1;
    endfunction

    localparam int NUM_DIGITS_DEF = num_digits(WIDTH_DEF, DIGIT_DEF);
    localparam int IDX_W_DEF      = $clog2(NUM_DIGITS_DEF);

endpackage

// File: rtl/max_uint64_serial_if.sv
// Operand-in / result-out valid-ready bus of the serial max unit.
interface max_uint64_serial_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             Y_sel;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Y, Y_sel
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Y, Y_sel
    );
endinterface

// File: rtl/max_uint64_serial_cmp_digit.sv
// One-digit unsigned comparator: gt means the B digit exceeds the A digit.
module cmp_digit_uint #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             eq
);
    assign gt = (b > a);
    assign eq = (b == a);
endmodule

// File: rtl/max_uint64_serial.sv
// Bit-serial MSB-first unsigned max. Define MAX_UINT_EARLY_EXIT_EN to stop the
// compare at the first differing digit; otherwise all digits are always walked.
module max_uint64_serial
    import max_uint_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 4
) (
    input logic               clk,
    input logic               rst,
    max_uint64_serial_if.slave bus
);
    localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int IDX_W      = idx_width(NUM_DIGITS);

`ifdef MAX_UINT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of DIGIT");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [IDX_W-1:0]   idx;
    logic               decided;
    logic               sel;

    logic [DIGIT-1:0]   a_digit;
    logic [DIGIT-1:0]   b_digit;
    logic               digit_gt;
    logic               digit_eq;
    logic               decide_now;
    logic               next_sel;
    logic               last_digit;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        a_digit    = a_reg[int'(idx)*DIGIT +: DIGIT];
        b_digit    = b_reg[int'(idx)*DIGIT +: DIGIT];
        decide_now = !decided && !digit_eq;
        next_sel   = decide_now ? digit_gt : sel;
        last_digit = (idx == '0) || (EARLY_EXIT && decide_now);
    end

    cmp_digit_uint #(.DIGIT(DIGIT)) u_cmp (
        .a  (a_digit),
        .b  (b_digit),
        .gt (digit_gt),
        .eq (digit_eq)
    );

    assign bus.in_ready = (state == IDLE);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            decided       <= 1'b0;
            sel           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.Y         <= '0;
            bus.Y_sel     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // NOTE: operand registers are pure datapath, always
                        // loaded before use, so they carry no reset.
                        a_reg   <= bus.A;
                        b_reg   <= bus.B;
                        idx     <= IDX_W'(NUM_DIGITS - 1);
                        decided <= 1'b0;
                        sel     <= 1'b0;
                        state   <= CMP;
                    end
                end
                CMP: begin
                    if (decide_now) begin
                        decided <= 1'b1;
                        sel     <= digit_gt;
                    end
                    if (last_digit) begin
                        bus.Y         <= next_sel ? b_reg : a_reg;
                        bus.Y_sel     <= next_sel;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
